// File: rtl/new_usb_ohci_pkg.sv
// Shared types for the OHCI root-port PHY: USB line states, receive error codes
// and the receiver FSM encoding.
package new_usb_ohci_pkg;

  typedef enum logic [1:0] {LS_SE0, LS_J, LS_K, LS_SE1} usb_line_e;

  typedef enum logic [1:0] {RX_OK, RX_STUFF, RX_ALIGN, RX_SE1} rx_err_e;

  typedef enum logic [2:0] {
    RXS_IDLE,
    RXS_SYNC,
    RXS_DATA,
    RXS_EOP,
    RXS_ERR
  } rx_state_e;

  localparam int unsigned UsbStuffLimit = 6;

  // Map raw {dp, dm} pin levels onto a line state.
  function automatic usb_line_e line_decode(input logic [1:0] dpdm);
    usb_line_e ls;
    unique case (dpdm)
      2'b00:   ls = LS_SE0;
      2'b10:   ls = LS_J;
      2'b01:   ls = LS_K;
      default: ls = LS_SE1;
    endcase
    return ls;
  endfunction

endpackage

// File: rtl/new_usb_rx_sampler.sv
// Line-side front end: two-flop synchronizer on D+/D- and a bit-phase counter
// that re-centres on every line transition and strobes mid-bit.
module new_usb_rx_sampler
  import new_usb_ohci_pkg::*;
#(
  parameter int unsigned OversampleRate = 4
) (
  input  logic      phy_clk_i,
  input  logic      phy_rst_i,
  input  logic      phy_dp_i,
  input  logic      phy_dm_i,
  output usb_line_e line_o,
  output logic      strobe_o
);

  localparam int unsigned PhaseW = $clog2(OversampleRate);
  localparam logic [PhaseW-1:0] PhaseMax = PhaseW'(OversampleRate - 1);
  localparam logic [PhaseW-1:0] PhaseMid = PhaseW'(OversampleRate / 2);

  logic [1:0]        meta_q;
  usb_line_e         line_q;
  logic [PhaseW-1:0] phase_q;
  logic [PhaseW-1:0] phase_d;
  logic              strobe_q;

  // Phase restarts when the second stage is about to take a new line state,
  // so phase 0 always coincides with the first cycle of a new level.
  always_comb begin
    phase_d = (phase_q == PhaseMax) ? '0 : phase_q + PhaseW'(1);
    if (line_decode(meta_q) != line_q) begin
      phase_d = '0;
    end
  end

  always_ff @(posedge phy_clk_i) begin
    if (phy_rst_i) begin
      meta_q   <= 2'b10;
      line_q   <= LS_J;
      phase_q  <= '0;
      strobe_q <= 1'b0;
    end else begin
      meta_q   <= {phy_dp_i, phy_dm_i};
      line_q   <= line_decode(meta_q);
      phase_q  <= phase_d;
      strobe_q <= (phase_d == PhaseMid);
    end
  end

  assign line_o   = line_q;
  assign strobe_o = strobe_q;

endmodule

// File: rtl/new_usb_phy_rx.sv
// Full-speed USB receive front end: SYNC detect, NRZI decode, destuffing,
// LSB-first byte assembly, EOP detection and error reporting.
module new_usb_phy_rx
  import new_usb_ohci_pkg::*;
#(
  parameter int unsigned OversampleRate = 4,
  parameter int unsigned SyncZeros      = 3
) (
  input  logic       phy_clk_i,
  input  logic       phy_rst_i,
  input  logic       rx_en_i,
  input  logic       phy_dp_i,
  input  logic       phy_dm_i,
  output logic       rx_active_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_eop_o,
  output rx_err_e    rx_err_o
);

  localparam int unsigned ZeroW = $clog2(SyncZeros + 1);
  localparam logic [ZeroW-1:0] ZeroSat    = ZeroW'(SyncZeros);
  localparam logic [2:0]       StuffLimit = 3'(UsbStuffLimit);

  usb_line_e line_s;
  logic      strobe_s;

  new_usb_rx_sampler #(
    .OversampleRate(OversampleRate)
  ) u_sampler (
    .phy_clk_i (phy_clk_i),
    .phy_rst_i (phy_rst_i),
    .phy_dp_i  (phy_dp_i),
    .phy_dm_i  (phy_dm_i),
    .line_o    (line_s),
    .strobe_o  (strobe_s)
  );

  rx_state_e        state_q, state_d;
  usb_line_e        prev_q, prev_d;
  logic [ZeroW-1:0] zero_q, zero_d;
  logic [2:0]       ones_q, ones_d;
  logic [2:0]       bitc_q, bitc_d;
  logic [7:0]       shift_q, shift_d;
  logic             align_q, align_d;
  logic             jseen_q, jseen_d;
  logic             active_q, active_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             eop_q, eop_d;
  rx_err_e          err_q, err_d;

  logic       nrzi_bit;
  logic       enter_err;
  rx_err_e    err_code;
  logic [7:0] shift_in;

  // NRZI: no transition between samples is a 1.
  assign nrzi_bit = (line_s == prev_q);
  assign shift_in = {nrzi_bit, shift_q[7:1]};

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    zero_d    = zero_q;
    ones_d    = ones_q;
    bitc_d    = bitc_q;
    shift_d   = shift_q;
    align_d   = align_q;
    jseen_d   = jseen_q;
    active_d  = active_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    eop_d     = 1'b0;
    err_d     = RX_OK;
    enter_err = 1'b0;
    err_code  = RX_OK;

    if (strobe_s) begin
      unique case (state_q)
        RXS_IDLE: begin
          if (line_s == LS_K) begin
            state_d = RXS_SYNC;
            zero_d  = ZeroW'(1);
            prev_d  = LS_K;
          end
        end
        RXS_SYNC: begin
          if (line_s == LS_J || line_s == LS_K) begin
            prev_d = line_s;
            if (!nrzi_bit) begin
              if (zero_q < ZeroSat) zero_d = zero_q + ZeroW'(1);
            end else if (zero_q >= ZeroSat) begin
              state_d  = RXS_DATA;
              active_d = 1'b1;
              ones_d   = 3'd1;
              bitc_d   = 3'd0;
              align_d  = 1'b0;
            end else begin
              state_d = RXS_IDLE;
            end
          end else begin
            state_d = RXS_IDLE;
          end
        end
        RXS_DATA: begin
          case (line_s)
            LS_SE0: begin
              state_d = RXS_EOP;
              align_d = (bitc_q != 3'd0);
            end
            LS_SE1: begin
              enter_err = 1'b1;
              err_code  = RX_SE1;
            end
            default: begin
              prev_d = line_s;
              if (ones_q == StuffLimit) begin
                if (nrzi_bit) begin
                  enter_err = 1'b1;
                  err_code  = RX_STUFF;
                end else begin
                  ones_d = 3'd0;
                end
              end else begin
                ones_d  = nrzi_bit ? ones_q + 3'd1 : 3'd0;
                shift_d = shift_in;
                bitc_d  = bitc_q + 3'd1;
                if (bitc_q == 3'd7) begin
                  data_d  = shift_in;
                  valid_d = 1'b1;
                end
              end
            end
          endcase
        end
        RXS_EOP: begin
          case (line_s)
            LS_SE0: ;
            LS_J: begin
              state_d  = RXS_IDLE;
              eop_d    = 1'b1;
              err_d    = align_q ? RX_ALIGN : RX_OK;
              active_d = 1'b0;
            end
            LS_K: begin
              enter_err = 1'b1;
              err_code  = RX_ALIGN;
            end
            default: begin
              enter_err = 1'b1;
              err_code  = RX_SE1;
            end
          endcase
        end
        RXS_ERR: begin
          // Two consecutive J samples mark the bus as idle again.
          if (line_s == LS_J) begin
            jseen_d = 1'b1;
            if (jseen_q) begin
              state_d = RXS_IDLE;
              jseen_d = 1'b0;
            end
          end else begin
            jseen_d = 1'b0;
          end
        end
        default: state_d = RXS_IDLE;
      endcase
    end

    if (enter_err) begin
      state_d  = RXS_ERR;
      eop_d    = 1'b1;
      err_d    = err_code;
      active_d = 1'b0;
      jseen_d  = 1'b0;
    end

    // Disabling the receiver abandons any packet without reporting it.
    if (!rx_en_i) begin
      state_d  = RXS_IDLE;
      zero_d   = '0;
      ones_d   = 3'd0;
      bitc_d   = 3'd0;
      shift_d  = 8'd0;
      align_d  = 1'b0;
      jseen_d  = 1'b0;
      active_d = 1'b0;
      valid_d  = 1'b0;
      eop_d    = 1'b0;
      err_d    = RX_OK;
    end
  end

  always_ff @(posedge phy_clk_i) begin
    if (phy_rst_i) begin
      state_q  <= RXS_IDLE;
      prev_q   <= LS_J;
      zero_q   <= '0;
      ones_q   <= 3'd0;
      bitc_q   <= 3'd0;
      shift_q  <= 8'd0;
      align_q  <= 1'b0;
      jseen_q  <= 1'b0;
      active_q <= 1'b0;
      data_q   <= 8'd0;
      valid_q  <= 1'b0;
      eop_q    <= 1'b0;
      err_q    <= RX_OK;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      zero_q   <= zero_d;
      ones_q   <= ones_d;
      bitc_q   <= bitc_d;
      shift_q  <= shift_d;
      align_q  <= align_d;
      jseen_q  <= jseen_d;
      active_q <= active_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      eop_q    <= eop_d;
      err_q    <= err_d;
    end
  end

  assign rx_active_o = active_q;
  assign rx_data_o   = data_q;
  assign rx_valid_o  = valid_q;
  assign rx_eop_o    = eop_q;
  assign rx_err_o    = err_q;

endmodule

// File: tb/tb_new_usb_phy_rx.sv
// Bench for new_usb_phy_rx: a bit-level USB transmitter model drives the pins and
// a byte/EOP scoreboard derived from the transmitted bits checks the outputs.
module tb_new_usb_phy_rx;
  import new_usb_ohci_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       dp;
  logic       dm;
  logic       active;
  logic [7:0] data;
  logic       valid;
  logic       eop;
  rx_err_e    err;

  always #5 clk = ~clk;

  new_usb_phy_rx #(
    .OversampleRate(4),
    .SyncZeros     (3)
  ) dut (
    .phy_clk_i  (clk),
    .phy_rst_i  (rst),
    .rx_en_i    (en),
    .phy_dp_i   (dp),
    .phy_dm_i   (dm),
    .rx_active_o(active),
    .rx_data_o  (data),
    .rx_valid_o (valid),
    .rx_eop_o   (eop),
    .rx_err_o   (err)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  rx_err_e    exp_err_q[$];
  bit         tx_bits[$];
  int         n_valid = 0;
  int         n_eop = 0;
  int         n_stuff = 0;
  logic [7:0] last_data = 8'd0;
  rx_err_e    last_err = RX_OK;
  bit         saw_active = 1'b0;
  bit         jitter = 1'b0;
  bit         jit_phase = 1'b0;
  usb_line_e  cur = LS_J;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Scoreboard: every emitted byte and EOP must match the model queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (active) saw_active = 1'b1;
      check("valid_eop_exclusive", int'(valid && eop), 0);
      if (!eop) check("err_ok_outside_eop", int'(err), int'(RX_OK));
      if (valid) begin
        n_valid++;
        last_data = data;
        check("active_during_byte", int'(active), 1);
        check("byte_was_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("byte_value", int'(data), int'(exp_q.pop_front()));
      end
      if (eop) begin
        n_eop++;
        last_err = err;
        check("active_low_at_eop", int'(active), 0);
        check("eop_was_expected", int'(exp_err_q.size() != 0), 1);
        if (exp_err_q.size() != 0) check("eop_err_code", int'(err), int'(exp_err_q.pop_front()));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input usb_line_e ls, input int cyc);
    case (ls)
      LS_J:    {dp, dm} = 2'b10;
      LS_K:    {dp, dm} = 2'b01;
      LS_SE0:  {dp, dm} = 2'b00;
      default: {dp, dm} = 2'b11;
    endcase
    repeat (cyc) @(negedge clk);
  endtask

  // One bit time: 4 clocks nominal, or alternating 3/5 clocks when jittered.
  task automatic send_line(input usb_line_e ls);
    int n;
    if (jitter) begin
      jit_phase = !jit_phase;
      n = jit_phase ? 3 : 5;
    end else begin
      n = 4;
    end
    drive(ls, n);
  endtask

  task automatic send_nrzi(input bit b);
    if (!b) cur = (cur == LS_J) ? LS_K : LS_J;
    send_line(cur);
  endtask

  task automatic send_sync();
    cur = LS_J;
    for (int i = 0; i < 7; i++) send_nrzi(1'b0);
    send_nrzi(1'b1);
  endtask

  // Transmit tx_bits; the closing SYNC 1 counts toward the stuffing run.
  task automatic send_data(input bit stuff);
    int ones = 1;
    foreach (tx_bits[i]) begin
      send_nrzi(tx_bits[i]);
      ones = tx_bits[i] ? ones + 1 : 0;
      if (stuff && ones == int'(UsbStuffLimit)) begin
        send_nrzi(1'b0);
        ones = 0;
        n_stuff++;
      end
    end
  endtask

  task automatic send_eop();
    send_line(LS_SE0);
    send_line(LS_SE0);
    cur = LS_J;
    send_line(LS_J);
  endtask

  task automatic idle(input int bits);
    cur = LS_J;
    repeat (bits) send_line(LS_J);
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) tx_bits.push_back(b[i]);
  endtask

  // Expected outputs: every complete group of 8 bits is a byte; leftovers mean misalignment.
  task automatic model_packet();
    int nb = tx_bits.size();
    for (int k = 0; k < nb / 8; k++) begin
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[i] = tx_bits[8 * k + i];
      exp_q.push_back(b);
    end
    exp_err_q.push_back((nb % 8 != 0) ? RX_ALIGN : RX_OK);
  endtask

  task automatic packet();
    model_packet();
    send_sync();
    send_data(1'b1);
    send_eop();
    idle(6);
    tx_bits.delete();
  endtask

  task automatic drained(input string name);
    check({name, "_bytes_left"}, exp_q.size(), 0);
    check({name, "_eops_left"}, exp_err_q.size(), 0);
  endtask

  int v0, e0;

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    {dp, dm} = 2'b10;
    repeat (3) @(negedge clk);
    check("reset_active", int'(active), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_eop", int'(eop), 0);
    check("reset_data", int'(data), 0);
    check("reset_err", int'(err), int'(RX_OK));
    rst = 1'b0;
    idle(4);

    // Single byte.
    v0 = n_valid; e0 = n_eop;
    add_byte(8'hA5);
    packet();
    check("t1_valid_count", n_valid - v0, 1);
    check("t1_data", int'(last_data), 'hA5);
    check("t1_eop_count", n_eop - e0, 1);
    check("t1_err", int'(last_err), int'(RX_OK));
    check("t1_active_after", int'(active), 0);
    drained("t1");

    // Stuff bit after the sixth one (SYNC 1 + five data ones).
    v0 = n_valid; n_stuff = 0;
    add_byte(8'hFF);
    add_byte(8'h01);
    packet();
    check("t2_stuff_bits", n_stuff, 1);
    check("t2_valid_count", n_valid - v0, 2);
    check("t2_last_data", int'(last_data), 'h01);
    check("t2_err", int'(last_err), int'(RX_OK));
    drained("t2");

    // Seven ones without stuffing, then exactly two J bits before the next SYNC.
    v0 = n_valid; e0 = n_eop;
    exp_err_q.push_back(RX_STUFF);
    for (int i = 0; i < 7; i++) tx_bits.push_back(1'b1);
    send_sync();
    send_data(1'b0);
    tx_bits.delete();
    idle(2);
    check("t3_valid_count", n_valid - v0, 0);
    check("t3_eop_count", n_eop - e0, 1);
    check("t3_err", int'(last_err), int'(RX_STUFF));
    check("t3_active_after", int'(active), 0);
    add_byte(8'h3C);
    packet();
    check("t3_recover_data", int'(last_data), 'h3C);
    drained("t3");

    // Twelve data bits: one byte, then misaligned EOP.
    v0 = n_valid;
    add_byte(8'hA5);
    tx_bits.push_back(1'b0);
    tx_bits.push_back(1'b1);
    tx_bits.push_back(1'b1);
    tx_bits.push_back(1'b0);
    packet();
    check("t4_valid_count", n_valid - v0, 1);
    check("t4_data", int'(last_data), 'hA5);
    check("t4_err", int'(last_err), int'(RX_ALIGN));
    drained("t4");

    // Alternating 3/5-clock bit periods.
    v0 = n_valid;
    jitter = 1'b1;
    jit_phase = 1'b0;
    add_byte(8'h00);
    add_byte(8'h55);
    add_byte(8'hC3);
    packet();
    jitter = 1'b0;
    idle(2);
    check("t5_valid_count", n_valid - v0, 3);
    check("t5_last_data", int'(last_data), 'hC3);
    check("t5_err", int'(last_err), int'(RX_OK));
    drained("t5");

    // Truncated SYNC: idle->K and K->J give two zeros, then J,J is a one.
    v0 = n_valid; e0 = n_eop;
    saw_active = 1'b0;
    send_line(LS_K);
    send_line(LS_J);
    send_line(LS_J);
    idle(6);
    check("t6_valid_count", n_valid - v0, 0);
    check("t6_eop_count", n_eop - e0, 0);
    check("t6_never_active", int'(saw_active), 0);

    // Reset mid-byte, then a clean packet.
    e0 = n_eop;
    send_sync();
    send_nrzi(1'b1); send_nrzi(1'b0); send_nrzi(1'b1); send_nrzi(1'b0);
    check("t7_active_mid_packet", int'(active), 1);
    {dp, dm} = 2'b10;
    cur = LS_J;
    rst = 1'b1;
    @(negedge clk);
    check("t7_active_after_rst", int'(active), 0);
    check("t7_valid_after_rst", int'(valid), 0);
    rst = 1'b0;
    idle(6);
    check("t7_no_eop", n_eop - e0, 0);
    add_byte(8'h5A);
    packet();
    check("t7_recover_data", int'(last_data), 'h5A);
    drained("t7");

    // Receiver disabled mid-byte; rest of that packet is ignored.
    v0 = n_valid; e0 = n_eop;
    send_sync();
    send_nrzi(1'b1); send_nrzi(1'b0); send_nrzi(1'b1); send_nrzi(1'b0);
    check("t8_active_mid_packet", int'(active), 1);
    en = 1'b0;
    @(negedge clk);
    check("t8_active_after_dis", int'(active), 0);
    send_nrzi(1'b0); send_nrzi(1'b1); send_nrzi(1'b0); send_nrzi(1'b1);
    send_eop();
    idle(4);
    check("t8_no_valid", n_valid - v0, 0);
    check("t8_no_eop", n_eop - e0, 0);
    en = 1'b1;
    idle(4);
    add_byte(8'h81);
    packet();
    check("t8_recover_data", int'(last_data), 'h81);
    check("t8_recover_err", int'(last_err), int'(RX_OK));
    drained("t8");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
